// File: rtl/oled_frame_streamer.sv
// Scans a WIDTHxHEIGHT frame through pixel_index, captures the renderers' RGB565 reply
// and streams a window-set command prologue plus pixel words to the OLED over 4-wire SPI.
module oled_frame_streamer #(
  parameter int WIDTH     = 96,
  parameter int HEIGHT    = 64,
  parameter int CLK_DIV   = 1,
  parameter int FRAME_GAP = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] oled_data,
  output logic [12:0] pixel_index,
  output logic        sclk,
  output logic        mosi,
  output logic        cs_n,
  output logic        dc,
  output logic        frame_begin,
  output logic        busy
);

  localparam int N = WIDTH * HEIGHT;
  localparam logic [12:0] LAST_PIX = 13'(N - 1);
  localparam logic [7:0]  COL_END  = 8'(WIDTH - 1);
  localparam logic [7:0]  ROW_END  = 8'(HEIGHT - 1);
  localparam logic [47:0] CMD_SEQ  = {8'h15, 8'h00, COL_END, 8'h75, 8'h00, ROW_END};
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(FRAME_GAP - 1);

  typedef enum logic [2:0] {IDLE, CMD, FETCH, SHIFT, GAP} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic             phase, phase_nxt;
  logic [5:0]       bit_cnt, bit_nxt;
  logic             fetch_cnt, fetch_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
  logic [15:0]      shreg, shreg_nxt;
  logic [12:0]      pix, pix_nxt;
  logic             half_end, bit_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      div_cnt   <= '0;
      phase     <= 1'b0;
      bit_cnt   <= '0;
      fetch_cnt <= 1'b0;
      gap_cnt   <= '0;
      shreg     <= '0;
      pix       <= '0;
    end else begin
      state     <= state_nxt;
      div_cnt   <= div_nxt;
      phase     <= phase_nxt;
      bit_cnt   <= bit_nxt;
      fetch_cnt <= fetch_nxt;
      gap_cnt   <= gap_nxt;
      shreg     <= shreg_nxt;
      pix       <= pix_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    phase_nxt = phase;
    bit_nxt   = bit_cnt;
    fetch_nxt = fetch_cnt;
    gap_nxt   = gap_cnt;
    shreg_nxt = shreg;
    pix_nxt   = pix;
    half_end  = (div_cnt == DIV_LAST);
    bit_end   = half_end && phase;

    // phase 0 is the sclk-low half of a bit, phase 1 the sclk-high half
    if (state == CMD || state == SHIFT) begin
      if (half_end) begin
        div_nxt   = '0;
        phase_nxt = ~phase;
      end else begin
        div_nxt = div_cnt + 1'b1;
      end
    end

    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = CMD;
          div_nxt   = '0;
          phase_nxt = 1'b0;
          bit_nxt   = '0;
        end
      end
      CMD: begin
        if (bit_end) begin
          if (bit_cnt == 6'd47) begin
            state_nxt = FETCH;
            bit_nxt   = '0;
            fetch_nxt = 1'b0;
          end else begin
            bit_nxt = bit_cnt + 1'b1;
          end
        end
      end
      FETCH: begin
        if (fetch_cnt) begin
          shreg_nxt = oled_data;
          state_nxt = SHIFT;
          bit_nxt   = '0;
          div_nxt   = '0;
          phase_nxt = 1'b0;
        end else begin
          fetch_nxt = 1'b1;
        end
      end
      SHIFT: begin
        if (bit_end) begin
          shreg_nxt = {shreg[14:0], 1'b0};
          if (bit_cnt == 6'd15) begin
            bit_nxt   = '0;
            fetch_nxt = 1'b0;
            if (pix == LAST_PIX) begin
              pix_nxt   = '0;
              state_nxt = GAP;
              gap_nxt   = '0;
            end else begin
              pix_nxt   = pix + 1'b1;
              state_nxt = FETCH;
            end
          end else begin
            bit_nxt = bit_cnt + 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          gap_nxt = '0;
          if (enable) begin
            state_nxt = CMD;
            div_nxt   = '0;
            phase_nxt = 1'b0;
            bit_nxt   = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          gap_nxt = gap_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode straight from state so an async reset reaches the pins immediately
  assign busy        = (state != IDLE);
  assign cs_n        = (state == IDLE) || (state == GAP);
  assign dc          = (state == FETCH) || (state == SHIFT);
  assign sclk        = ((state == CMD) || (state == SHIFT)) && phase;
  assign mosi        = (state == CMD)   ? CMD_SEQ[6'd47 - bit_cnt] :
                       (state == SHIFT) ? shreg[15] : 1'b0;
  assign frame_begin = (state == CMD) && (bit_cnt == 6'd0) && !phase && (div_cnt == '0);
  assign pixel_index = pix;

endmodule

// File: tb/tb_oled_frame_streamer.sv
// Bench for oled_frame_streamer: an SPI-decoding monitor pops expected command bytes and
// pixel words from a queue filled by the stimulus, using a reduced frame height.
`timescale 1ns/1ps
module tb_oled_frame_streamer;

  localparam int W        = 96;
  localparam int H        = 4;
  localparam int CD       = 1;
  localparam int FG       = 16;
  localparam int N        = W * H;
  localparam int PIX_CLKS = 2 + 32 * CD;
  localparam int PERIOD   = 96 * CD + N * PIX_CLKS + FG;
  localparam int LIMIT    = 2 * PERIOD;

  typedef struct packed {
    logic        dc;
    logic [15:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] oled_data;
  logic [12:0] pixel_index;
  logic        sclk, mosi, cs_n, dc, frame_begin, busy;

  logic [15:0] mem [0:8191];
  exp_t        expq[$];
  int          total = 0;
  int          bad = 0;
  int          fb_count = 0;

  always #5 clk = ~clk;

  oled_frame_streamer #(
    .WIDTH(W), .HEIGHT(H), .CLK_DIV(CD), .FRAME_GAP(FG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .oled_data(oled_data),
    .pixel_index(pixel_index), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
    .dc(dc), .frame_begin(frame_begin), .busy(busy)
  );

  // Renderer model: registered lookup, valid one clk after pixel_index changes
  always @(posedge clk) oled_data <= mem[pixel_index];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // One frame's worth of expected SPI traffic, then drive enable
  task automatic applyStimulus(input logic en_val);
    logic [7:0] cmd [6];
    cmd = '{8'h15, 8'h00, 8'(W - 1), 8'h75, 8'h00, 8'(H - 1)};
    for (int b = 0; b < 6; b++) expq.push_back('{dc: 1'b0, val: {8'h00, cmd[b]}});
    for (int i = 0; i < N; i++) expq.push_back('{dc: 1'b1, val: mem[i]});
    enable = en_val;
  endtask

  int          cyc = 0;
  int          last_fb = 0;
  bit          have_fb = 0;
  logic        prev_sclk = 0;
  int          nbits = 0;
  logic [15:0] acc = '0;
  int          gap_run = 0;
  int          hold_run = 0;
  logic [12:0] prev_pix = '0;
  exp_t        e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_sclk = 0; nbits = 0; acc = '0; have_fb = 0;
      gap_run = 0; hold_run = 0; prev_pix = '0;
    end else begin
      cyc++;
      if (sclk && !prev_sclk) begin
        acc = {acc[14:0], mosi};
        nbits++;
        if (nbits == (dc ? 16 : 8)) begin
          if (expq.size() == 0) begin
            checkOutput("unexpected_word", 32'(acc), 32'hFFFF_FFFF);
          end else begin
            e = expq.pop_front();
            checkOutput(dc ? "pix_word" : "cmd_byte", 32'({dc, acc}), 32'({e.dc, e.val}));
          end
          nbits = 0;
          acc = '0;
        end
      end
      prev_sclk = sclk;

      if (!busy) have_fb = 0;
      if (frame_begin) begin
        fb_count++;
        checkOutput("fb_state", 32'({pixel_index, dc, cs_n}), 32'd0);
        if (have_fb) checkOutput("frame_period", cyc - last_fb, PERIOD);
        last_fb = cyc;
        have_fb = 1;
      end

      if (busy && cs_n) begin
        gap_run++;
      end else begin
        if (gap_run != 0) checkOutput("gap_len", gap_run, FG);
        gap_run = 0;
      end

      if (pixel_index != prev_pix) begin
        checkOutput("pix_hold", hold_run, PIX_CLKS);
        checkOutput("pix_next", 32'(pixel_index),
                    (prev_pix == 13'(N - 1)) ? 32'd0 : 32'(prev_pix) + 32'd1);
        hold_run = 0;
        prev_pix = pixel_index;
      end
      if (dc) hold_run++;
    end
  end

  initial begin
    int n;
    rst_n  = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
    mem[0] = 16'hF800;
    mem[1] = 16'h07E0;
    repeat (8) begin
      @(negedge clk);
      checkOutput("reset_outputs",
                  32'({sclk, mosi, cs_n, dc, busy, frame_begin, pixel_index}),
                  32'({6'b001000, 13'd0}));
    end

    // Frame A: fixed first two pixels, random remainder
    applyStimulus(1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!(busy && cs_n) && n < LIMIT) begin @(negedge clk); n++; end
    checkOutput("wait_gap_a", 32'(n < LIMIT), 32'd1);
    checkOutput("queue_after_a", expq.size(), 0);

    // Frame B: index pattern, enable dropped halfway through
    for (int i = 0; i < 8192; i++) mem[i] = 16'(i);
    applyStimulus(1'b1);
    n = 0;
    while (pixel_index != 13'(N / 2) && n < LIMIT) begin @(negedge clk); n++; end
    checkOutput("wait_mid_b", 32'(n < LIMIT), 32'd1);
    enable = 1'b0;
    n = 0;
    while (busy && n < LIMIT) begin @(negedge clk); n++; end
    checkOutput("wait_idle_b", 32'(n < LIMIT), 32'd1);
    @(negedge clk);
    checkOutput("queue_after_b", expq.size(), 0);
    checkOutput("frames_seen", fb_count, 2);
    repeat (4) begin
      repeat (10) @(negedge clk);
      checkOutput("idle_after_drop", 32'({busy, cs_n, sclk, mosi, dc}), 32'({5'b01000}));
    end
    checkOutput("no_new_frame", fb_count, 2);

    // Frame C: random data, aborted by reset during bit 7 of pixel 100
    for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
    applyStimulus(1'b1);
    n = 0;
    while (pixel_index != 13'd100 && n < LIMIT) begin @(negedge clk); n++; end
    checkOutput("wait_pix100", 32'(n < LIMIT), 32'd1);
    repeat (16) @(posedge clk);
    #2;
    checkOutput("mid_shift", 32'({busy, dc, sclk}), 32'({3'b110}));
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset",
                32'({sclk, mosi, cs_n, dc, busy, frame_begin, pixel_index}),
                32'({6'b001000, 13'd0}));
    expq.delete();
    repeat (4) @(negedge clk);

    // Frame D: fresh prologue after reset, then run to completion
    applyStimulus(1'b1);
    rst_n = 1'b1;
    n = 0;
    while (!frame_begin && n < LIMIT) begin @(negedge clk); n++; end
    checkOutput("wait_restart", 32'(n < LIMIT), 32'd1);
    checkOutput("restart_pix0", 32'(pixel_index), 32'd0);
    enable = 1'b0;
    n = 0;
    while (busy && n < LIMIT) begin @(negedge clk); n++; end
    checkOutput("wait_idle_d", 32'(n < LIMIT), 32'd1);
    @(negedge clk);
    checkOutput("queue_after_d", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
